uart_doc_receiver: RTL and testbench

//   Serial inbound path for the document: UART 8N1 receiver on RsRx. It is the counterpart of the

---
 rtl/uart_doc_receiver_if.sv | 29 ++
 rtl/uart_doc_receiver.sv | 173 +++++++++++++++++
 tb/tb_uart_doc_receiver.sv | 329 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_doc_receiver_if.sv
// ============================================================================
// Module      : uart_doc_receiver_if
// Description : Document RAM write port handshake (ready/valid style).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface uart_doc_receiver_if;
    logic       doc_wr_ready;
    logic       doc_we;
    logic [8:0] doc_addr;
    logic [7:0] doc_data;

    modport master (
        input  doc_wr_ready,
        output doc_we,
        output doc_addr,
        output doc_data
    );

    modport slave (
        output doc_wr_ready,
        input  doc_we,
        input  doc_addr,
        input  doc_data
    );
endinterface

`default_nettype wire

// File: rtl/uart_doc_receiver.sv
// ============================================================================
// Module      : uart_doc_receiver
// Description : UART 8N1 receiver writing printable bytes into the document
//               RAM at a wrapping text cursor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_doc_receiver #(
    parameter int CLKS_PER_BIT = 10416,
    parameter int COLS         = 20,
    parameter int ROWS         = 15
) (
    input  wire logic            clk,
    input  wire logic            rst_n,
    input  wire logic            RsRx,
    input  wire logic            clear,
    uart_doc_receiver_if.master  doc,
    output logic                 rx_busy,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam int             TW       = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0]  BIT_END  = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0]  HALF_END = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [4:0]     COL_LAST = 5'(COLS - 1);
    localparam logic [3:0]     ROW_LAST = 4'(ROWS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    logic          rx_meta;
    logic          rx_sync;
    logic          rx_prev;
    logic [1:0]    sync_fill;

    state_t        state;
    logic [TW-1:0] timer;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic [3:0]    row;
    logic [4:0]    col;

    logic          fall;
    logic          printable;
    logic [4:0]    col_inc;
    logic [3:0]    row_inc;
    logic [3:0]    row_adv;

    // rx_prev only tracks the line once the synchroniser holds real samples,
    // so a line held low through reset cannot fake a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta   <= 1'b1;
            rx_sync   <= 1'b1;
            rx_prev   <= 1'b0;
            sync_fill <= 2'b00;
        end else begin
            rx_meta   <= RsRx;
            rx_sync   <= rx_meta;
            sync_fill <= {sync_fill[0], 1'b1};
            rx_prev   <= sync_fill[1] ? rx_sync : 1'b0;
        end
    end

    assign fall      = rx_prev & ~rx_sync;
    assign printable = (shift >= 8'h20) && (shift <= 8'h7E);
    assign col_inc   = (col == COL_LAST) ? 5'd0 : col + 5'd1;
    assign row_inc   = (row == ROW_LAST) ? 4'd0 : row + 4'd1;
    assign row_adv   = (col == COL_LAST) ? row_inc : row;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            timer        <= '0;
            bit_idx      <= 3'd0;
            shift        <= 8'h00;
            row          <= 4'd0;
            col          <= 5'd0;
            rx_busy      <= 1'b0;
            frame_err    <= 1'b0;
            overrun      <= 1'b0;
            doc.doc_we   <= 1'b0;
            doc.doc_addr <= 9'd0;
            doc.doc_data <= 8'h00;
        end else begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            if (doc.doc_we && doc.doc_wr_ready) begin
                doc.doc_we <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    if (fall) begin
                        state   <= S_START;
                        timer   <= '0;
                        rx_busy <= 1'b1;
                    end
                end
                S_START: begin
                    if (timer == HALF_END) begin
                        timer <= '0;
                        if (!rx_sync) begin
                            state   <= S_DATA;
                            bit_idx <= 3'd0;
                        end else begin
                            state   <= S_IDLE;
                            rx_busy <= 1'b0;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                S_DATA: begin
                    if (timer == BIT_END) begin
                        timer   <= '0;
                        shift   <= {rx_sync, shift[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            state <= S_STOP;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                S_STOP: begin
                    if (timer == BIT_END) begin
                        timer   <= '0;
                        state   <= S_IDLE;
                        rx_busy <= 1'b0;
                        if (!rx_sync) begin
                            frame_err <= 1'b1;
                        end else if (shift == 8'h0D) begin
                            col <= 5'd0;
                            row <= row_inc;
                        end else if (printable) begin
                            // A still-pending write keeps its slot; the new byte is lost.
                            if (doc.doc_we) begin
                                overrun <= 1'b1;
                            end else begin
                                doc.doc_we   <= 1'b1;
                                doc.doc_addr <= {row, col};
                                doc.doc_data <= shift;
                                col          <= col_inc;
                                row          <= row_adv;
                            end
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    rx_busy <= 1'b0;
                end
            endcase

            if (clear) begin
                row <= 4'd0;
                col <= 5'd0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_uart_doc_receiver.sv
// ============================================================================
// Module      : tb_uart_doc_receiver
// Description : Self-checking bench for uart_doc_receiver (table + model).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_doc_receiver;

    localparam int CPB  = 16;
    localparam int COLS = 20;
    localparam int ROWS = 15;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic rx    = 1'b1;
    logic clear = 1'b0;
    logic busy, ferr, ovr;

    uart_doc_receiver_if dif ();

    uart_doc_receiver #(.CLKS_PER_BIT(CPB), .COLS(COLS), .ROWS(ROWS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .RsRx      (rx),
        .clear     (clear),
        .doc       (dif),
        .rx_busy   (busy),
        .frame_err (ferr),
        .overrun   (ovr)
    );

    always #5 clk = ~clk;

    // Observed traffic
    logic [8:0] got_addr[$];
    logic [7:0] got_data[$];
    int ferr_cnt = 0;
    int ovr_cnt  = 0;
    int busy_cyc = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (dif.doc_we && dif.doc_wr_ready) begin
                got_addr.push_back(dif.doc_addr);
                got_data.push_back(dif.doc_data);
            end
            if (ferr) ferr_cnt++;
            if (ovr)  ovr_cnt++;
            if (busy) busy_cyc++;
        end
    end

    // Reference model: text cursor on a COLS x ROWS page, row-major 32-wide map
    int m_row = 0, m_col = 0, m_ferr = 0;
    logic [8:0] exp_addr[$];
    logic [7:0] exp_data[$];
    int g_base = 0, e_rd = 0;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endtask

    task automatic model_byte(input logic [7:0] b, input logic stop);
        if (!stop) begin
            m_ferr++;
        end else if (b == 8'h0D) begin
            m_col = 0;
            m_row = (m_row + 1) % ROWS;
        end else if (b >= 8'h20 && b <= 8'h7E) begin
            exp_addr.push_back(9'(m_row * 32 + m_col));
            exp_data.push_back(b);
            m_col = m_col + 1;
            if (m_col == COLS) begin
                m_col = 0;
                m_row = (m_row + 1) % ROWS;
            end
        end
    endtask

    task automatic sync_model();
        g_base = got_addr.size();
        exp_addr.delete();
        exp_data.delete();
        e_rd = 0;
    endtask

    task automatic check_writes(input string nm);
        int n;
        chk({nm, " write count"}, got_addr.size() - g_base, exp_addr.size());
        n = (got_addr.size() - g_base < exp_addr.size()) ? got_addr.size() - g_base : exp_addr.size();
        for (int i = e_rd; i < n; i++) begin
            chk({nm, " addr"}, got_addr[g_base + i], exp_addr[i]);
            chk({nm, " data"}, got_data[g_base + i], exp_data[i]);
        end
        if (n > e_rd) e_rd = n;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        repeat (2 * CPB) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        rx    = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        m_row = 0;
        m_col = 0;
        repeat (4) @(negedge clk);
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        m_row = 0;
        m_col = 0;
    endtask

    typedef struct {
        logic [7:0] b;
        logic       stop;
        int         nwr;
        logic [8:0] addr;
        logic [7:0] data;
        int         nferr;
    } vec_t;

    vec_t tbl[11];

    initial begin
        int n0, f0, o0, b0, fz;
        logic [7:0] rb;
        logic       rs;

        tbl[0]  = '{8'h41, 1'b1, 1, 9'h000, 8'h41, 0};
        tbl[1]  = '{8'h42, 1'b1, 1, 9'h001, 8'h42, 0};
        tbl[2]  = '{8'h0D, 1'b1, 0, 9'h000, 8'h00, 0};
        tbl[3]  = '{8'h0A, 1'b1, 0, 9'h000, 8'h00, 0};
        tbl[4]  = '{8'h43, 1'b1, 1, 9'h020, 8'h43, 0};
        tbl[5]  = '{8'h44, 1'b0, 0, 9'h000, 8'h00, 1};
        tbl[6]  = '{8'h45, 1'b1, 1, 9'h021, 8'h45, 0};
        tbl[7]  = '{8'h7F, 1'b1, 0, 9'h000, 8'h00, 0};
        tbl[8]  = '{8'h1F, 1'b1, 0, 9'h000, 8'h00, 0};
        tbl[9]  = '{8'h20, 1'b1, 1, 9'h022, 8'h20, 0};
        tbl[10] = '{8'h7E, 1'b1, 1, 9'h023, 8'h7E, 0};

        dif.doc_wr_ready = 1'b1;

        // Reset values
        repeat (3) @(negedge clk);
        chk("reset doc_we",    dif.doc_we,   0);
        chk("reset doc_addr",  dif.doc_addr, 0);
        chk("reset doc_data",  dif.doc_data, 0);
        chk("reset rx_busy",   busy,         0);
        chk("reset frame_err", ferr,         0);
        chk("reset overrun",   ovr,          0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Table-driven single frames
        for (int i = 0; i < 11; i++) begin
            n0 = got_addr.size();
            f0 = ferr_cnt;
            send_frame(tbl[i].b, tbl[i].stop);
            chk($sformatf("vec%0d writes", i), got_addr.size() - n0, tbl[i].nwr);
            chk($sformatf("vec%0d frame_err", i), ferr_cnt - f0, tbl[i].nferr);
            if (got_addr.size() - n0 == 1 && tbl[i].nwr == 1) begin
                chk($sformatf("vec%0d addr", i), got_addr[n0], tbl[i].addr);
                chk($sformatf("vec%0d data", i), got_data[n0], tbl[i].data);
            end
        end

        // Column wrap: 20 printable bytes then 'Z'
        do_reset();
        sync_model();
        for (int i = 0; i < 20; i++) begin
            model_byte(8'(8'h30 + i), 1'b1);
            send_frame(8'(8'h30 + i), 1'b1);
        end
        model_byte(8'h5A, 1'b1);
        send_frame(8'h5A, 1'b1);
        check_writes("colwrap");
        chk("colwrap 20th addr", (got_addr.size() >= g_base + 21) ? got_addr[g_base + 19] : 9'h1FF, 9'h013);
        chk("colwrap Z addr",    (got_addr.size() >= g_base + 21) ? got_addr[g_base + 20] : 9'h1FF, 9'h020);

        // Short glitch on idle line
        n0 = got_addr.size();
        f0 = ferr_cnt;
        b0 = busy_cyc;
        @(negedge clk);
        rx = 1'b0;
        @(negedge clk);
        rx = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        chk("glitch busy seen", (busy_cyc - b0) != 0, 1);
        chk("glitch busy back", busy, 0);
        chk("glitch writes", got_addr.size() - n0, 0);
        chk("glitch frame_err", ferr_cnt - f0, 0);
        model_byte(8'h67, 1'b1);
        send_frame(8'h67, 1'b1);
        check_writes("after glitch");

        // Overrun with write port withheld
        dif.doc_wr_ready = 1'b0;
        o0 = ovr_cnt;
        model_byte(8'h58, 1'b1);
        send_frame(8'h58, 1'b1);
        chk("hold doc_we",   dif.doc_we,   1);
        chk("hold doc_data", dif.doc_data, 8'h58);
        chk("hold doc_addr", dif.doc_addr, exp_addr[exp_addr.size() - 1]);
        send_frame(8'h59, 1'b1);
        chk("overrun pulses", ovr_cnt - o0, 1);
        chk("hold2 doc_data", dif.doc_data, 8'h58);
        chk("hold2 doc_addr", dif.doc_addr, exp_addr[exp_addr.size() - 1]);
        dif.doc_wr_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("released doc_we", dif.doc_we, 0);
        check_writes("overrun");
        model_byte(8'h4B, 1'b1);
        send_frame(8'h4B, 1'b1);
        check_writes("after overrun");

        // Page wrap: cursor to {14,19}, then 'Q','R'
        do_reset();
        sync_model();
        for (int i = 0; i < 14; i++) begin
            model_byte(8'h0D, 1'b1);
            send_frame(8'h0D, 1'b1);
        end
        for (int i = 0; i < 19; i++) begin
            model_byte(8'h61, 1'b1);
            send_frame(8'h61, 1'b1);
        end
        model_byte(8'h51, 1'b1);
        send_frame(8'h51, 1'b1);
        model_byte(8'h52, 1'b1);
        send_frame(8'h52, 1'b1);
        check_writes("pagewrap");
        n0 = got_addr.size();
        chk("pagewrap Q addr", (n0 >= 2) ? got_addr[n0 - 2] : 9'h1FF, 9'h1D3);
        chk("pagewrap R addr", (n0 >= 1) ? got_addr[n0 - 1] : 9'h1FF, 9'h000);

        // Reset mid-DATA with a write pending: the write is lost
        dif.doc_wr_ready = 1'b0;
        send_frame(8'h50, 1'b1);
        chk("pending before reset", dif.doc_we, 1);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            rx = i[0];
            repeat (CPB) @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        chk("midreset doc_we",   dif.doc_we,   0);
        chk("midreset doc_addr", dif.doc_addr, 0);
        chk("midreset doc_data", dif.doc_data, 0);
        chk("midreset rx_busy",  busy,         0);
        @(negedge clk);
        rx = 1'b1;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        m_row = 0;
        m_col = 0;
        dif.doc_wr_ready = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        sync_model();
        model_byte(8'h4D, 1'b1);
        send_frame(8'h4D, 1'b1);
        check_writes("after midreset");

        // clear: cursor only; a pending write keeps its latched address
        model_byte(8'h61, 1'b1);
        send_frame(8'h61, 1'b1);
        pulse_clear();
        model_byte(8'h63, 1'b1);
        send_frame(8'h63, 1'b1);
        dif.doc_wr_ready = 1'b0;
        model_byte(8'h70, 1'b1);
        send_frame(8'h70, 1'b1);
        pulse_clear();
        dif.doc_wr_ready = 1'b1;
        repeat (3) @(negedge clk);
        model_byte(8'h71, 1'b1);
        send_frame(8'h71, 1'b1);
        check_writes("clear");

        // Randomised traffic against the model
        fz = ferr_cnt;
        m_ferr = 0;
        for (int i = 0; i < 40; i++) begin
            int r;
            r  = $urandom_range(0, 9);
            rb = (r < 6) ? 8'($urandom_range(32, 126)) :
                 (r < 7) ? 8'h0D : 8'($urandom_range(0, 255));
            rs = ($urandom_range(0, 9) != 0);
            model_byte(rb, rs);
            send_frame(rb, rs);
            check_writes($sformatf("rand%0d", i));
        end
        chk("rand frame_err total", ferr_cnt - fz, m_ferr);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
